frame_scan_ctrl: RTL

FRAME_SCAN_CTRL -- requirements
Module: frame_scan_ctrl

---
 rtl/sgm_frame_pkg.sv | 18 +
 rtl/frame_xy_counter.sv | 37 +++
 rtl/frame_scan_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sgm_frame_pkg.sv
// Shared constants and state encoding for the SGM frame scan controller.
package sgm_frame_pkg;

  localparam int COORD_W    = 11;
  localparam int HIT_W      = 21;
  localparam int DISP_W     = 7;
  localparam int DEF_WIDTH  = 1280;
  localparam int DEF_HEIGHT = 1080;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_e;

endpackage

// File: rtl/frame_xy_counter.sv
// Raster column/row counter: column wraps at WIDTH-1 and carries into the row.
module frame_xy_counter
  import sgm_frame_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               clear,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               last_col,
  output logic               last_row
);

  assign last_col = (col == COORD_W'(WIDTH - 1));
  assign last_row = (row == COORD_W'(HEIGHT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_scan_ctrl.sv
// Frame scan controller: warm-up, raster pixel offer with backpressure, pipeline
// drain, and counting of filtered disparities that fall inside a window.
module frame_scan_ctrl
  import sgm_frame_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int WARMUP   = 50000,
  parameter int PIPE_LAT = 16,
  parameter int DISP_LO  = 16,
  parameter int DISP_HI  = 35
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               pix_ready,
  output logic               pix_valid,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  input  logic               result_valid,
  input  logic [DISP_W-1:0]  result,
  output logic [HIT_W-1:0]   hit_cnt,
  output logic               busy,
  output logic               done
);

  localparam int WU_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int DR_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  scan_state_e     state;
  logic [WU_W-1:0] wu_cnt;
  logic [DR_W-1:0] dr_cnt;

  logic launch, active, xfer, in_window;
  logic last_col, last_row;
  logic eol_nxt, row_last_nxt;

  assign active    = (state == ST_WARMUP) || (state == ST_SCAN) || (state == ST_DRAIN);
  assign launch    = ((state == ST_IDLE) || (state == ST_DONE)) && start && !abort;
  assign xfer      = (state == ST_SCAN) && pix_valid && pix_ready && !abort;
  assign in_window = result_valid && (result >= DISP_W'(DISP_LO)) && (result <= DISP_W'(DISP_HI));

  frame_xy_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_xy (
    .clk      (clk),
    .reset    (reset),
    .inc      (xfer),
    .clear    (launch),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last_row (last_row)
  );

  // Qualifiers of the pixel that follows the current one, so they can be registered.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    eol_nxt      = 1'b0;
    row_last_nxt = 1'b0;
    if (last_col) begin
      eol_nxt      = (WIDTH == 1);
      row_last_nxt = (row == COORD_W'(HEIGHT - 2));
    end else begin
      eol_nxt      = (col == COORD_W'(WIDTH - 2));
      row_last_nxt = last_row;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wu_cnt    <= '0;
      dr_cnt    <= '0;
      pix_valid <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      hit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (((state == ST_SCAN) || (state == ST_DRAIN)) && in_window && (hit_cnt != '1))
        hit_cnt <= hit_cnt + 1'b1;

      if (abort && active) begin
        state     <= ST_IDLE;
        pix_valid <= 1'b0;
        sof       <= 1'b0;
        eol       <= 1'b0;
        eof       <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (launch) begin
              state   <= ST_WARMUP;
              wu_cnt  <= '0;
              hit_cnt <= '0;
              busy    <= 1'b1;
              done    <= 1'b0;
            end
          end
          ST_WARMUP: begin
            if (wu_cnt == WU_W'(WARMUP - 1)) begin
              state     <= ST_SCAN;
              pix_valid <= 1'b1;
              sof       <= 1'b1;
              eol       <= (WIDTH == 1);
              eof       <= (WIDTH == 1) && (HEIGHT == 1);
            end else begin
              wu_cnt <= wu_cnt + 1'b1;
            end
          end
          ST_SCAN: begin
            if (xfer) begin
              if (eof) begin
                state     <= ST_DRAIN;
                pix_valid <= 1'b0;
                sof       <= 1'b0;
                eol       <= 1'b0;
                eof       <= 1'b0;
                dr_cnt    <= '0;
              end else begin
                sof <= 1'b0;
                eol <= eol_nxt;
                eof <= eol_nxt && row_last_nxt;
              end
            end
          end
          ST_DRAIN: begin
            if (dr_cnt == DR_W'(PIPE_LAT - 1)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              dr_cnt <= dr_cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
